// File: rtl/cgol_pkg.sv
// Shared types and helpers for the Game-of-Life next-generation datapath.
package cgol_pkg;

  localparam int DEF_ROWS = 16;
  localparam int DEF_COLS = 8;

  typedef logic [DEF_COLS-1:0] row_t;

  typedef enum logic [2:0] {
    IDLE,
    PRIME0,
    PRIME1,
    RUN,
    DONE
  } state_t;

  // Conway rule for one cell given its current value and live-neighbour count.
  function automatic logic live_next(input logic self, input logic [3:0] n);
    return self ? (n == 4'd2 || n == 4'd3) : (n == 4'd3);
  endfunction

endpackage

// File: rtl/cgol_row_rule.sv
// Combinational Conway rule for one row, given the rows above and below it.
module cgol_row_rule
  import cgol_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int WRAP = 1
) (
  input  logic [COLS-1:0] i_above,
  input  logic [COLS-1:0] i_cur,
  input  logic [COLS-1:0] i_below,
  output logic [COLS-1:0] o_next
);

  for (genvar c = 0; c < COLS; c++) begin : g_cell
    localparam int LI = (c == 0) ? COLS - 1 : c - 1;
    localparam int RI = (c == COLS - 1) ? 0 : c + 1;
    // Edge columns see a dead neighbour column when the board does not wrap.
    localparam bit HAS_L = (WRAP != 0) || (c > 0);
    localparam bit HAS_R = (WRAP != 0) || (c < COLS - 1);

    logic [2:0] w_left;
    logic [2:0] w_right;
    logic [3:0] w_n;

    assign w_left  = HAS_L ? {i_above[LI], i_cur[LI], i_below[LI]} : 3'b000;
    assign w_right = HAS_R ? {i_above[RI], i_cur[RI], i_below[RI]} : 3'b000;

    assign w_n = 4'(w_left[0]) + 4'(w_left[1]) + 4'(w_left[2])
               + 4'(w_right[0]) + 4'(w_right[1]) + 4'(w_right[2])
               + 4'(i_above[c]) + 4'(i_below[c]);

    assign o_next[c] = live_next(i_cur[c], w_n);
  end

endmodule

// File: rtl/next_gen_engine.sv
// Generation sequencer: streams the board through a 3-row window, applies the
// Conway rule and writes each next-generation row one cycle later.
module next_gen_engine
  import cgol_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int WRAP = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(ROWS)-1:0]         raddr,
  input  logic [COLS-1:0]                 rdata,
  output logic                            nwe,
  output logic [$clog2(ROWS)-1:0]         naddr,
  output logic [COLS-1:0]                 nwd,
  output logic [$clog2(ROWS*COLS+1)-1:0]  pop_count,
  output logic                            stable
);

  localparam int AW = $clog2(ROWS);
  localparam int PW = $clog2(ROWS*COLS+1);

  if (WRAP == 0 && ROWS == 1) begin : g_illegal
    $error("next_gen_engine: WRAP=0 requires ROWS > 1");
  end

  state_t          r_state;
  logic [AW-1:0]   r_k;
  logic [COLS-1:0] r_above;
  logic [COLS-1:0] r_cur;
  logic            r_busy;
  logic            r_done;
  logic            r_nwe;
  logic [AW-1:0]   r_naddr;
  logic [COLS-1:0] r_nwd;
  logic [AW-1:0]   r_raddr;
  logic [PW-1:0]   r_pop_acc;
  logic            r_stable_acc;
  logic [PW-1:0]   r_pop_count;
  logic            r_stable;

  logic            w_last;
  logic [COLS-1:0] w_below;
  logic [COLS-1:0] w_next;
  logic [PW-1:0]   w_row_pop;
  logic [PW-1:0]   w_pop_sum;
  logic            w_stable_sum;
  logic [AW-1:0]   w_raddr_step;

  assign w_last       = (r_k == AW'(ROWS - 1));
  // The row below the last one is dead on a non-wrapping board.
  assign w_below      = (w_last && WRAP == 0) ? '0 : rdata;
  assign w_pop_sum    = r_pop_acc + w_row_pop;
  assign w_stable_sum = r_stable_acc & (w_next == r_cur);
  assign w_raddr_step = AW'((int'(r_k) + 2) % ROWS);

  cgol_row_rule #(
    .COLS (COLS),
    .WRAP (WRAP)
  ) u_rule (
    .i_above (r_above),
    .i_cur   (r_cur),
    .i_below (w_below),
    .o_next  (w_next)
  );

  always_comb begin
    w_row_pop = '0;
    for (int i = 0; i < COLS; i++) begin
      w_row_pop = w_row_pop + PW'(w_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_k          <= '0;
      r_above      <= '0;
      r_cur        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_nwe        <= 1'b0;
      r_naddr      <= '0;
      r_nwd        <= '0;
      r_raddr      <= '0;
      r_pop_acc    <= '0;
      r_stable_acc <= 1'b0;
      r_pop_count  <= '0;
      r_stable     <= 1'b0;
    end else begin
      r_nwe  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_raddr <= '0;
          if (start) begin
            r_state <= PRIME0;
            r_busy  <= 1'b1;
            r_raddr <= AW'(ROWS - 1);
          end
        end
        PRIME0: begin
          r_above <= (WRAP != 0) ? rdata : '0;
          r_raddr <= '0;
          r_state <= PRIME1;
        end
        PRIME1: begin
          r_cur        <= rdata;
          r_pop_acc    <= '0;
          r_stable_acc <= 1'b1;
          r_k          <= '0;
          r_raddr      <= AW'(1 % ROWS);
          r_state      <= RUN;
        end
        RUN: begin
          r_nwe        <= 1'b1;
          r_naddr      <= r_k;
          r_nwd        <= w_next;
          r_pop_acc    <= w_pop_sum;
          r_stable_acc <= w_stable_sum;
          r_above      <= r_cur;
          r_cur        <= w_below;
          r_k          <= r_k + 1'b1;
          r_raddr      <= w_raddr_step;
          if (w_last) begin
            // Final write, done pulse and result update all land together.
            r_state     <= DONE;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_pop_count <= w_pop_sum;
            r_stable    <= w_stable_sum;
            r_raddr     <= '0;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign raddr     = r_raddr;
  assign nwe       = r_nwe;
  assign naddr     = r_naddr;
  assign nwd       = r_nwd;
  assign pop_count = r_pop_count;
  assign stable    = r_stable;

endmodule

// File: tb/tb_next_gen_engine.sv
// Directed and random generations on a wrapping and a non-wrapping engine,
// checked cycle by cycle against a cell-by-cell neighbour-count model.
module tb_next_gen_engine;

  localparam int ROWS     = 16;
  localparam int COLS     = 8;
  localparam int AW       = $clog2(ROWS);
  localparam int PW       = $clog2(ROWS*COLS+1);
  localparam int DONE_CYC = ROWS + 3;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  logic start;
  always #5 clk = ~clk;

  // Index 0: WRAP=0 engine, index 1: WRAP=1 engine
  logic            busy_v   [2];
  logic            done_v   [2];
  logic            nwe_v    [2];
  logic            stable_v [2];
  logic [AW-1:0]   raddr_v  [2];
  logic [AW-1:0]   naddr_v  [2];
  logic [COLS-1:0] rdata_v  [2];
  logic [COLS-1:0] nwd_v    [2];
  logic [PW-1:0]   pop_v    [2];

  logic [COLS-1:0] board [ROWS];

  assign rdata_v[0] = board[raddr_v[0]];
  assign rdata_v[1] = board[raddr_v[1]];

  next_gen_engine #(.ROWS(ROWS), .COLS(COLS), .WRAP(0)) u_dut_nowrap (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy_v[0]), .done(done_v[0]), .raddr(raddr_v[0]), .rdata(rdata_v[0]),
    .nwe(nwe_v[0]), .naddr(naddr_v[0]), .nwd(nwd_v[0]),
    .pop_count(pop_v[0]), .stable(stable_v[0])
  );

  next_gen_engine #(.ROWS(ROWS), .COLS(COLS), .WRAP(1)) u_dut_wrap (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy_v[1]), .done(done_v[1]), .raddr(raddr_v[1]), .rdata(rdata_v[1]),
    .nwe(nwe_v[1]), .naddr(naddr_v[1]), .nwd(nwd_v[1]),
    .pop_count(pop_v[1]), .stable(stable_v[1])
  );

  // Scoreboard
  logic [AW+COLS-1:0] exp_q0[$];
  logic [AW+COLS-1:0] exp_q1[$];
  logic [COLS-1:0]    exp_rows [2][ROWS];
  int                 exp_pop    [2];
  bit                 exp_stable [2];
  int                 prev_pop    [2];
  bit                 prev_stable [2];
  int                 n_cmp = 0;
  int                 n_err = 0;

  task automatic chk(input string tag, input int w, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, w, obs, exp);
    end
  endtask

  // Reference: count the 8 neighbours of every cell directly on the board.
  function automatic void compute_model(input int w);
    int n, rr, cc;
    bit alive;
    exp_pop[w]    = 0;
    exp_stable[w] = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              rr = r + dr;
              cc = c + dc;
              if (w == 1) begin
                rr = (rr + ROWS) % ROWS;
                cc = (cc + COLS) % COLS;
                n += int'(board[rr][cc]);
              end else if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
                n += int'(board[rr][cc]);
              end
            end
          end
        end
        alive = board[r][c] ? (n == 2 || n == 3) : (n == 3);
        exp_rows[w][r][c] = alive;
        exp_pop[w] += int'(alive);
      end
      if (exp_rows[w][r] != board[r]) exp_stable[w] = 1'b0;
    end
  endfunction

  task automatic check_cycle(input int mode, input int c, input int w);
    bit                 aborted;
    bit                 e_busy, e_nwe, e_done, e_stable, got;
    int                 e_raddr, e_pop;
    logic [AW+COLS-1:0] item;
    aborted  = (mode == 2 && c >= 9);
    e_busy   = aborted ? 1'b0 : (c >= 1 && c <= ROWS + 2);
    e_nwe    = aborted ? 1'b0 : (c >= 4 && c <= ROWS + 3);
    e_done   = (mode != 2) && (c == DONE_CYC);
    if (aborted)                       e_raddr = 0;
    else if (c == 1)                   e_raddr = ROWS - 1;
    else if (c >= 3 && c <= ROWS + 2)  e_raddr = (c - 2) % ROWS;
    else                               e_raddr = 0;
    if (aborted) begin
      e_pop = 0; e_stable = 1'b0;
    end else if (c >= DONE_CYC) begin
      e_pop = exp_pop[w]; e_stable = exp_stable[w];
    end else begin
      e_pop = prev_pop[w]; e_stable = prev_stable[w];
    end
    chk($sformatf("busy@%0d", c),   w, 32'(busy_v[w]),   32'(e_busy));
    chk($sformatf("done@%0d", c),   w, 32'(done_v[w]),   32'(e_done));
    chk($sformatf("nwe@%0d", c),    w, 32'(nwe_v[w]),    32'(e_nwe));
    chk($sformatf("raddr@%0d", c),  w, 32'(raddr_v[w]),  32'(e_raddr));
    chk($sformatf("pop@%0d", c),    w, 32'(pop_v[w]),    32'(e_pop));
    chk($sformatf("stable@%0d", c), w, 32'(stable_v[w]), 32'(e_stable));
    if (aborted) begin
      chk($sformatf("naddr_rst@%0d", c), w, 32'(naddr_v[w]), 32'd0);
      chk($sformatf("nwd_rst@%0d", c),   w, 32'(nwd_v[w]),   32'd0);
    end
    if (nwe_v[w] === 1'b1) begin
      got  = 1'b0;
      item = '0;
      if (w == 0 && exp_q0.size() > 0) begin item = exp_q0.pop_front(); got = 1'b1; end
      if (w == 1 && exp_q1.size() > 0) begin item = exp_q1.pop_front(); got = 1'b1; end
      if (got) begin
        chk($sformatf("naddr@%0d", c), w, 32'(naddr_v[w]), 32'(item[AW+COLS-1:COLS]));
        chk($sformatf("nwd@%0d", c),   w, 32'(nwd_v[w]),   32'(item[COLS-1:0]));
      end
    end
  endtask

  // mode 0: plain pass, 1: extra starts at cycles 3, 10 and the done cycle,
  // 2: reset during RUN k=5 (cycle 8)
  task automatic run_pass(input int mode);
    compute_model(0);
    compute_model(1);
    exp_q0.delete();
    exp_q1.delete();
    for (int r = 0; r < ROWS; r++) begin
      exp_q0.push_back({AW'(r), exp_rows[0][r]});
      exp_q1.push_back({AW'(r), exp_rows[1][r]});
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= ROWS + 8; c++) begin
      @(negedge clk);
      for (int w = 0; w < 2; w++) check_cycle(mode, c, w);
      if (mode == 1) start = (c == 3 || c == 10 || c == DONE_CYC);
      if (mode == 2 && c == 8) reset = 1'b1;
      if (mode == 2 && c == 9) reset = 1'b0;
    end
    start = 1'b0;
    chk("writes_left", 0, 32'(exp_q0.size()), (mode == 2) ? 32'(ROWS - 5) : 32'd0);
    chk("writes_left", 1, 32'(exp_q1.size()), (mode == 2) ? 32'(ROWS - 5) : 32'd0);
    for (int w = 0; w < 2; w++) begin
      prev_pop[w]    = (mode == 2) ? 0 : exp_pop[w];
      prev_stable[w] = (mode == 2) ? 1'b0 : exp_stable[w];
    end
  endtask

  task automatic clear_board();
    for (int r = 0; r < ROWS; r++) board[r] = '0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    clear_board();
    prev_pop    = '{0, 0};
    prev_stable = '{1'b0, 1'b0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      chk("rst_busy",   w, 32'(busy_v[w]),   32'd0);
      chk("rst_done",   w, 32'(done_v[w]),   32'd0);
      chk("rst_nwe",    w, 32'(nwe_v[w]),    32'd0);
      chk("rst_raddr",  w, 32'(raddr_v[w]),  32'd0);
      chk("rst_naddr",  w, 32'(naddr_v[w]),  32'd0);
      chk("rst_nwd",    w, 32'(nwd_v[w]),    32'd0);
      chk("rst_pop",    w, 32'(pop_v[w]),    32'd0);
      chk("rst_stable", w, 32'(stable_v[w]), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Blinker
    clear_board();
    board[7] = 8'b0011_1000;
    run_pass(0);

    // Block in the corner
    clear_board();
    board[0] = 8'b0000_0011;
    board[1] = 8'b0000_0011;
    run_pass(0);

    // Edge blinker, differs between wrapping and non-wrapping boards
    clear_board();
    board[0] = 8'b1000_0011;
    run_pass(0);

    // Empty board
    clear_board();
    run_pass(0);

    // Stray starts during a pass and on the done cycle
    clear_board();
    board[7] = 8'b0011_1000;
    run_pass(1);

    // Reset abort mid-RUN, then a fresh pass
    run_pass(2);
    run_pass(0);

    // Random boards
    for (int t = 0; t < 6; t++) begin
      for (int r = 0; r < ROWS; r++) begin
        board[r] = (t % 2 == 0) ? COLS'($urandom & $urandom) : COLS'($urandom_range(0, 255));
      end
      run_pass((t == 3) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
